mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port main memory (addr, write data, MEM_WD, MEM_RD, read data) between three requesters:
//  - program loader (LDR)
//  - control-FSM data access (DAT, load/store)
//  - instruction fetch (IFT)
//  Sits between the processor/loader and main memory, replacing the direct SEL_DIR address mux.
//  Sequences each access over the memory latency, returns read data with a one-cycle ack, and bounds fetch starvation.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width
//  MEM_LAT   1   cycles from strobe assertion to valid mem_read_data (1..15)
//  MAX_WAIT  3   consecutive DAT wins tolerated while IFT waits before IFT is forced (1..7)
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  boot_en        in   1   1 = loader mode (only LDR may be granted)
//  ldr_req        in   1   loader request (write only)
//  ldr_addr       in   AW  loader address
//  ldr_wdata      in   DW  loader write data
//  ldr_ack        out  1   one-cycle completion pulse
//  dat_req        in   1   data request
//  dat_we         in   1   1 = store, 0 = load
//  dat_addr       in   AW  data address
//  dat_wdata      in   DW  store data
//  dat_ack        out  1   one-cycle completion pulse
//  ift_req        in   1   fetch request (read only)
//  ift_addr       in   AW  fetch address (PC)
//  ift_ack        out  1   one-cycle completion pulse
//  rdata          out  DW  read data, valid in the ack cycle, held until the next ack
//  mem_dir        out  AW  memory address
//  mem_write_data out  DW  memory write data
//  mem_wd         out  1   memory write strobe
//  mem_rd         out  1   memory read strobe
//  mem_read_data  in   DW  memory read data
//  busy           out  1   1 while state != IDLE
//  grant_id       out  2   0 = none, 1 = LDR, 2 = DAT, 3 = IFT; registered
// BEHAVIOUR
//  Reset (async, reset = 0):
//  - State = IDLE; all outputs 0; wait counter = 0; latency counter = 0.
//  Handshake:
//  - A requester holds req, addr, wdata and we stable from assertion until the cycle after its ack.
//  - req may drop only after ack. An ack'd requester that still asserts req is treated as a new request.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//  - IDLE: arbitrate among pending requests. On a win, latch the winner's addr/wdata/we into internal registers, set grant_id, go to ACCESS.
//  - ACCESS: drive mem_dir/mem_write_data from the latched registers. Assert exactly one of mem_wd/mem_rd for exactly MEM_LAT cycles, then go to RESP.
//  - RESP: strobes low; pulse the winner's ack for one cycle. For reads, capture mem_read_data into rdata on the last ACCESS cycle. Go to IDLE. grant_id returns to 0.
//  Access time:
//  - Minimum req-to-ack time is MEM_LAT + 2 cycles.
//  - Back-to-back accesses leave one IDLE cycle between them.
//  Priority:
//  - boot_en = 1: only LDR is eligible; DAT/IFT requests wait and are never acked.
//  - boot_en = 0: LDR is ignored. DAT beats IFT, except when wait_cnt == MAX_WAIT; then IFT wins.
//  - wait_cnt increments when DAT wins while IFT is pending. It clears when IFT wins or IFT is not requesting. It saturates at MAX_WAIT.
//  Mode change: a boot_en change mid-access does not abort the access; it affects only the next arbitration.
//  Inputs during an access: requests arriving in ACCESS/RESP are ignored until IDLE. Latched registers isolate the memory from input changes.
//  Reset mid-access: strobes drop immediately (async); no ack is issued; the pending requester must re-request.
//  Writes: rdata is unchanged on writes.
//  Width: addresses pass through unmodified (byte/word alignment is the requester's concern). No arithmetic on the data path.
// STRUCTURE
//  Shared package (arbiter_defs.vh):
//  - state encodings ST_IDLE/ST_ACCESS/ST_RESP
//  - grant ID constants GNT_NONE/GNT_LDR/GNT_DAT/GNT_IFT
//  Sub-module arb_priority_sel (combinational):
//  - inputs: boot_en, three reqs, wait_cnt
//  - outputs: winner ID
//  Top block holds the FSM, latency counter, wait counter, latch registers and output regs.
// TESTING
//  1. Reset check: release reset with no requests -> all outputs 0, busy = 0 for 10 cycles.
//  2. Single fetch, MEM_LAT = 1: ift_req addr 0x00000004 with memory returning 0x8C220000 -> mem_rd high 1 cycle at mem_dir = 0x4; ift_ack at cycle 3; rdata = 0x8C220000.
//  3. Collision: dat_req (store 0xDEADBEEF @0x100) and ift_req asserted together -> DAT served first (mem_wd = 1, grant_id = 2), then IFT (grant_id = 3).
//  4. Starvation, MAX_WAIT = 3: DAT requests continuously while IFT waits -> exactly 3 DAT acks, then an IFT ack.
//  5. Boot mode: boot_en = 1 with ldr/dat/ift all requesting -> only ldr_ack occurs. boot_en -> 0: ldr ignored, DAT then IFT served.
//  6. Reset mid-ACCESS: assert reset during a DAT read -> mem_rd falls in the same cycle, no dat_ack. After release, a re-request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the main-memory port arbiter: FSM states, grant IDs
// and the widths of the internal counters.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_LDR  = 2'd1;
  localparam logic [1:0] GNT_DAT  = 2'd2;
  localparam logic [1:0] GNT_IFT  = 2'd3;

  // MEM_LAT tops out at 15, MAX_WAIT at 7
  localparam int LAT_W  = 4;
  localparam int WAIT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_priority_sel.sv
// Combinational winner selection: loader only in boot mode, otherwise data
// beats fetch unless fetch has been starved for MAX_WAIT data wins.
module arb_priority_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic              boot_en,
  input  logic              ldr_req,
  input  logic              dat_req,
  input  logic              ift_req,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic [1:0]        winner
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  always_comb begin
    winner = GNT_NONE;
    if (boot_en) begin
      if (ldr_req) winner = GNT_LDR;
    end else if (ift_req && (!dat_req || wait_cnt == WAIT_MAX)) begin
      winner = GNT_IFT;
    end else if (dat_req) begin
      winner = GNT_DAT;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between loader, data and fetch
// requesters: IDLE arbitrates, ACCESS strobes for MEM_LAT cycles, RESP acks.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          boot_en,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  input  logic          dat_req,
  input  logic          dat_we,
  input  logic [AW-1:0] dat_addr,
  input  logic [DW-1:0] dat_wdata,
  output logic          dat_ack,
  input  logic          ift_req,
  input  logic [AW-1:0] ift_addr,
  output logic          ift_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_dir,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_wd,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_read_data,
  output logic          busy,
  output logic [1:0]    grant_id
);

  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e              state, state_nxt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [1:0]          winner;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic                we_q;
  logic                last_acc;

  arb_priority_sel #(.MAX_WAIT(MAX_WAIT)) u_sel (
    .boot_en  (boot_en),
    .ldr_req  (ldr_req),
    .dat_req  (dat_req),
    .ift_req  (ift_req),
    .wait_cnt (wait_cnt),
    .winner   (winner)
  );

  assign last_acc = (lat_cnt == LAT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (winner != GNT_NONE) state_nxt = ST_ACCESS;
      ST_ACCESS: if (last_acc) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt  <= '0;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      grant_id <= GNT_NONE;
      rdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          lat_cnt  <= '0;
          grant_id <= winner;
          // starvation count only advances while fetch is actually waiting
          if (!ift_req || winner == GNT_IFT)
            wait_cnt <= '0;
          else if (winner == GNT_DAT && wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 1'b1;
          case (winner)
            GNT_LDR: begin addr_q <= ldr_addr; wdata_q <= ldr_wdata; we_q <= 1'b1;   end
            GNT_DAT: begin addr_q <= dat_addr; wdata_q <= dat_wdata; we_q <= dat_we; end
            GNT_IFT: begin addr_q <= ift_addr; wdata_q <= '0;        we_q <= 1'b0;   end
            default: ;
          endcase
        end
        ST_ACCESS: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (last_acc && !we_q) rdata <= mem_read_data;
        end
        ST_RESP: grant_id <= GNT_NONE;
        default: ;
      endcase
    end
  end

  // memory sees only the latched request, and only while strobing
  assign mem_dir        = (state == ST_ACCESS) ? addr_q  : '0;
  assign mem_write_data = (state == ST_ACCESS) ? wdata_q : '0;
  assign mem_wd         = (state == ST_ACCESS) &&  we_q;
  assign mem_rd         = (state == ST_ACCESS) && !we_q;
  assign busy           = (state != ST_IDLE);

  assign ldr_ack = (state == ST_RESP) && (grant_id == GNT_LDR);
  assign dat_ack = (state == ST_RESP) && (grant_id == GNT_DAT);
  assign ift_ack = (state == ST_RESP) && (grant_id == GNT_IFT);

endmodule
